// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control sequencer for the bus-based CPU datapath
//
// Purpose: steps the datapath through fetch (T0-T2), decode (T3) and the
// per-opcode execute states (T4-T7). It drives every bus-drive and load strobe,
// the register-field selects, the memory controls and the ALU op.
//
// Optional feature macro: CU_MULDIV_EN. When it is defined, the HIin/LOin/HIout/LOout
// ports are added and mul/div/mfhi/mflo execute. When it is not defined, those
// opcodes behave as nop.
//
// Ports:
//   Clock      in   rising-edge system clock
//   Clear      in   asynchronous active-low reset (forces RESET)
//   IR[31:0]   in   instruction register, opcode in IR[31:27]
//   CON_FF     in   branch condition flag from the datapath
//   Stop       in   halt request, sampled on every entry to T0
//   PCout..Cout       out  bus drive strobes
//   MARin..CONIn      out  load strobes
//   Gra/Grb/Grc       out  register field selects
//   IncPC/Read/Write  out  PC increment and memory control
//   HIin/LOin/HIout/LOout  out  HI/LO strobes (CU_MULDIV_EN only)
//   alu_op[4:0]  out  ALU operation; zero whenever Zin is low
//   Run          out  1 while sequencing, 0 in RESET or HALT
module control_sequencer #(
  parameter int OPW               = 5,
  parameter int RESET_VECTOR_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        OutPortin,
  output logic        Rin,
  output logic        Rout,
  output logic        CONIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
`ifdef CU_MULDIV_EN
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
`endif
  output logic [4:0]  alu_op,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_NEG, C_IMM, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_HALT, C_MULDIV, C_MFHI, C_MFLO
  } class_t;

  localparam int       CW     = $clog2(RESET_VECTOR_WAIT + 1) + 1;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01001;
  localparam logic [4:0] ALU_OR  = 5'b01010;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [4:0]      w_op;
  logic [4:0]      w_imm_op;
  class_t          w_class;
  state_t          w_entry;
  logic            w_unused;

  assign w_op     = 5'(IR[31 -: OPW]);
  assign w_unused = ^IR[31-OPW:0];
  // Stop is honoured only when entering T0, so an in-flight instruction always completes.
  assign w_entry  = Stop ? S_HALT : S_T0;

  always_comb begin
    w_class = C_NOP;
    case (w_op)
      5'd0:                                         w_class = C_LD;
      5'd1:                                         w_class = C_LDI;
      5'd2:                                         w_class = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: w_class = C_RALU;
      5'd11, 5'd12, 5'd13:                          w_class = C_IMM;
`ifdef CU_MULDIV_EN
      5'd14, 5'd15:                                 w_class = C_MULDIV;
      5'd23:                                        w_class = C_MFHI;
      5'd24:                                        w_class = C_MFLO;
`endif
      5'd16, 5'd17:                                 w_class = C_NEG;
      5'd18:                                        w_class = C_BR;
      5'd19:                                        w_class = C_JR;
      5'd20:                                        w_class = C_JAL;
      5'd21:                                        w_class = C_IN;
      5'd22:                                        w_class = C_OUT;
      5'd26:                                        w_class = C_HALT;
      default:                                      w_class = C_NOP;
    endcase
  end

  always_comb begin
    case (w_op)
      5'd12:   w_imm_op = ALU_AND;
      5'd13:   w_imm_op = ALU_OR;
      default: w_imm_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_wait_cnt == CW'(RESET_VECTOR_WAIT)) r_state <= w_entry;
          else r_wait_cnt <= r_wait_cnt + CW'(1);
        end
        S_T0: r_state <= S_T1;
        S_T1: r_state <= S_T2;
        // nop and unassigned opcodes skip decode entirely
        S_T2: r_state <= (w_class == C_NOP) ? w_entry : S_T3;
        S_T3: begin
          case (w_class)
            C_HALT:                             r_state <= S_HALT;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:  r_state <= w_entry;
            default:                            r_state <= S_T4;
          endcase
        end
        S_T4: r_state <= (w_class == C_JAL) ? w_entry : S_T5;
        S_T5: begin
          case (w_class)
            C_LD, C_ST, C_BR, C_MULDIV: r_state <= S_T6;
            default:                    r_state <= w_entry;
          endcase
        end
        S_T6:    r_state <= (w_class == C_LD || w_class == C_ST) ? S_T7 : w_entry;
        S_T7:    r_state <= w_entry;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RESET;
      endcase
    end
  end

  // Strobes are decoded from the present state rather than registered: IR is
  // loaded on the same edge that enters T3, and T3 must act on that new value.
  always_comb begin
    PCout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; InPortout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; OutPortin = 1'b0; Rin = 1'b0; Rout = 1'b0; CONIn = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
`ifdef CU_MULDIV_EN
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
`endif
    alu_op = 5'b0;
    Run    = (r_state != S_RESET) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (w_class)
          C_RALU, C_NEG, C_IMM, C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST:              begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:  begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
          C_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          C_IN:  begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
`ifdef CU_MULDIV_EN
          C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (w_class)
          C_RALU, C_MULDIV: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
          C_NEG:            begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
          C_IMM:            begin Cout = 1'b1; Zin = 1'b1; alu_op = w_imm_op; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          C_BR:             begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:            begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_class)
          C_RALU, C_NEG, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:       begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
`ifdef CU_MULDIV_EN
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (w_class)
          C_LD: begin Read = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
`ifdef CU_MULDIV_EN
          C_MULDIV: begin Zhiout = 1'b1; HIin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (w_class)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  localparam int WAIT = 1;
`ifdef CU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic CON_FF = 1'b0;
  logic Stop = 1'b0;
  logic PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, Rout, CONIn;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic HIin, LOin, HIout, LOout;
  logic [4:0] alu_op;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPW(5), .RESET_VECTOR_WAIT(WAIT)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .InPortout(InPortout), .BAout(BAout), .Cout(Cout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .OutPortin(OutPortin),
    .Rin(Rin), .Rout(Rout), .CONIn(CONIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write),
`ifdef CU_MULDIV_EN
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
`endif
    .alu_op(alu_op), .Run(Run)
  );

`ifndef CU_MULDIV_EN
  assign HIin = 1'b0; assign LOin = 1'b0; assign HIout = 1'b0; assign LOout = 1'b0;
`endif

  logic [32:0] w_obs;
  assign w_obs = {LOout, HIout, LOin, HIin, Write, Read, IncPC, Grc, Grb, Gra, CONIn,
                  Rout, Rin, OutPortin, Yin, IRin, MDRin, PCin, Zin, MARin, Cout, BAout,
                  InPortout, MDRout, Zlowout, Zhiout, PCout, alu_op, Run};

  localparam logic [32:0] R     = 33'd1;
  localparam logic [32:0] PCO   = 33'd1 << 6,  ZHI  = 33'd1 << 7,  ZLO  = 33'd1 << 8;
  localparam logic [32:0] MDRO  = 33'd1 << 9,  INP  = 33'd1 << 10, BAO  = 33'd1 << 11;
  localparam logic [32:0] CO    = 33'd1 << 12, MARI = 33'd1 << 13, ZI   = 33'd1 << 14;
  localparam logic [32:0] PCI   = 33'd1 << 15, MDRI = 33'd1 << 16, IRI  = 33'd1 << 17;
  localparam logic [32:0] YI    = 33'd1 << 18, OUTP = 33'd1 << 19, RI   = 33'd1 << 20;
  localparam logic [32:0] RO    = 33'd1 << 21, CONI = 33'd1 << 22, GA   = 33'd1 << 23;
  localparam logic [32:0] GB    = 33'd1 << 24, GC   = 33'd1 << 25, INC  = 33'd1 << 26;
  localparam logic [32:0] RD    = 33'd1 << 27, WR   = 33'd1 << 28, HII  = 33'd1 << 29;
  localparam logic [32:0] LOI   = 33'd1 << 30, HIO  = 33'd1 << 31, LOO  = 33'd1 << 32;

  logic [32:0] exp_q[$];

  function automatic logic [32:0] alu(input int code);
    return 33'(code) << 1;
  endfunction

  // Expected per-cycle strobe words for one instruction, straight from the microcode table.
  task automatic build_seq(input logic [31:0] ir, input bit con);
    int op;
    op = int'(ir[31:27]);
    exp_q.delete();
    exp_q.push_back(R | PCO | MARI | INC | ZI);
    exp_q.push_back(R | ZLO | PCI | RD | MDRI);
    exp_q.push_back(R | MDRO | IRI);
    if (op >= 3 && op <= 10 || op == 16 || op == 17) begin
      exp_q.push_back(R | GB | RO | YI);
      exp_q.push_back(R | ((op >= 16) ? GB : GC) | RO | ZI | alu(op));
      exp_q.push_back(R | ZLO | GA | RI);
    end else if (op >= 11 && op <= 13) begin
      exp_q.push_back(R | GB | RO | YI);
      exp_q.push_back(R | CO | ZI | alu(op == 11 ? 3 : op == 12 ? 9 : 10));
      exp_q.push_back(R | ZLO | GA | RI);
    end else if (op <= 2) begin
      exp_q.push_back(R | GB | BAO | YI);
      exp_q.push_back(R | CO | ZI | alu(3));
      if (op == 1) exp_q.push_back(R | ZLO | GA | RI);
      else begin
        exp_q.push_back(R | ZLO | MARI);
        if (op == 0) begin
          exp_q.push_back(R | RD | MDRI);
          exp_q.push_back(R | MDRO | GA | RI);
        end else begin
          exp_q.push_back(R | GA | RO | MDRI);
          exp_q.push_back(R | WR);
        end
      end
    end else if (op == 18) begin
      exp_q.push_back(R | GA | RO | CONI);
      exp_q.push_back(R | PCO | YI);
      exp_q.push_back(R | CO | ZI | alu(3));
      exp_q.push_back(R | ZLO | (con ? PCI : 33'd0));
    end else if (op == 19) exp_q.push_back(R | GA | RO | PCI);
    else if (op == 20) begin
      exp_q.push_back(R | PCO | GB | RI);
      exp_q.push_back(R | GA | RO | PCI);
    end else if (op == 21) exp_q.push_back(R | INP | GA | RI);
    else if (op == 22) exp_q.push_back(R | GA | RO | OUTP);
    else if (op == 26) exp_q.push_back(R);
    else if (MD && (op == 14 || op == 15)) begin
      exp_q.push_back(R | GB | RO | YI);
      exp_q.push_back(R | GC | RO | ZI | alu(op));
      exp_q.push_back(R | ZLO | LOI);
      exp_q.push_back(R | ZHI | HII);
    end else if (MD && op == 23) exp_q.push_back(R | HIO | GA | RI);
    else if (MD && op == 24) exp_q.push_back(R | LOO | GA | RI);
  endtask

  task automatic check(input string tag, input logic [32:0] expv);
    n_checks++;
    assert (w_obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, w_obs, expv);
    end
  endtask

  task automatic do_reset();
    Clear = 1'b0;
    #1 check("reset_async", 33'd0);
    repeat (2) begin @(negedge Clock); check("reset_hold", 33'd0); end
    Clear = 1'b1;
    repeat (WAIT) begin @(negedge Clock); check("reset_wait", 33'd0); end
  endtask

  // Called with the next negedge falling in T0. IR/CON_FF change only after T0 is checked,
  // so the previous instruction's final decisions still see its own IR.
  task automatic run_instr(input logic [31:0] ir, input bit con, input bit stop, input int abort_idx);
    int n;
    bit halted;
    build_seq(ir, con);
    n = exp_q.size();
    halted = (ir[31:27] == 5'd26);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check($sformatf("ir%08h_t%0d", ir, i), exp_q[i]);
      if (i == 0) begin IR = ir; CON_FF = con; end
      if (i == abort_idx) begin do_reset(); return; end
      if (i == n - 1 && stop) Stop = 1'b1;
    end
    if (halted || stop) begin
      repeat (3) begin @(negedge Clock); check("halted_idle", 33'd0); end
      Stop = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] rir;
    int rop;
    #2;
    do_reset();
    run_instr(32'h98800000, 1'b0, 1'b0, -1);  // jr R1
    run_instr(32'h19890000, 1'b0, 1'b0, -1);  // add R3,R1,R2
    run_instr(32'h01000065, 1'b0, 1'b0, -1);  // ld R2,0x65(R0)
    run_instr(32'h9280000E, 1'b0, 1'b0, -1);  // brzr, not taken
    run_instr(32'h9280000E, 1'b1, 1'b0, -1);  // brzr, taken
    run_instr(32'h11000010, 1'b0, 1'b0, -1);  // st
    run_instr(32'h08800003, 1'b0, 1'b0, -1);  // ldi
    run_instr(32'hA1000000, 1'b0, 1'b0, -1);  // jal
    run_instr(32'hC8000000, 1'b0, 1'b0, -1);  // nop
    run_instr(32'hF8000000, 1'b0, 1'b0, -1);  // unassigned opcode
    run_instr(32'h70000000, 1'b0, 1'b0, -1);  // mul
    run_instr(32'hB8800000, 1'b0, 1'b0, -1);  // mfhi
    run_instr(32'h81080000, 1'b0, 1'b0, -1);  // neg
    run_instr(32'h6108000F, 1'b0, 1'b0, -1);  // andi
    for (int k = 0; k < 60; k++) begin
      rop = int'($urandom_range(0, 31));
      if (rop == 26) rop = 25;
      rir = {5'(rop), 27'($urandom)};
      run_instr(rir, 1'($urandom_range(0, 1)), 1'b0, -1);
    end
    run_instr(32'h19890000, 1'b0, 1'b1, -1);  // Stop at end of add
    run_instr(32'h98800000, 1'b0, 1'b0, -1);
    run_instr(32'hD0000000, 1'b0, 1'b0, -1);  // halt
    run_instr(32'h19890000, 1'b0, 1'b0, 4);   // Clear during T4 of add
    run_instr(32'h01000065, 1'b0, 1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
